// File: rtl/pwm8carr_pkg.sv
// Shared enums and counter width for the 8-carrier PWM event scheduler.
`ifndef EVTCOUNT_WIDTH
`define EVTCOUNT_WIDTH 8
`endif

package pwm8carr_pkg;

  localparam int unsigned EVTCOUNT_WIDTH = `EVTCOUNT_WIDTH;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic [1:0] {
    NO_COUNT   = 2'd0,
    COUNT_ZERO = 2'd1,
    COUNT_PRD  = 2'd2,
    COUNT_BOTH = 2'd3
  } _count_mode;

  typedef enum logic {
    NO_MASK = 1'b0,
    MASK    = 1'b1
  } _mask_mode;

endpackage

// File: rtl/pwm_evt_chan.sv
// One carrier: strobe qualification, decimation counter, fire, pending request and overrun flag.
module pwm_evt_chan
  import pwm8carr_pkg::*;
#(
  parameter int unsigned EVT_W = `EVTCOUNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             evt_zero,
  input  logic             evt_prd,
  input  _pwm_onoff        pwm_onoff,
  input  _count_mode       countmode,
  input  _mask_mode        maskmode,
  input  logic [EVT_W-1:0] event_count,
  input  logic             ovr_clr,
  input  logic             granted,
  input  logic             accept,
  output logic             pend,
  output logic             irq,
  output logic             ovr
);

  logic [EVT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             irq_q, irq_d;
  logic             ovr_q, ovr_d;
  logic             q_c, off_c, fire_c;

  always_comb begin
    q_c    = 1'b0;
    off_c  = (pwm_onoff == OFF) || (countmode == NO_COUNT);
    fire_c = 1'b0;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;

    if (pwm_onoff == ON) begin
      q_c = (evt_zero && (countmode == COUNT_ZERO || countmode == COUNT_BOTH)) ||
            (evt_prd  && (countmode == COUNT_PRD  || countmode == COUNT_BOTH));
    end

    if (off_c) begin
      cnt_d = '0;
    end else if (q_c) begin
      if (maskmode == NO_MASK || cnt_q >= event_count) begin
        fire_c = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + EVT_W'(1);
      end
    end

    // A granted carrier keeps its request until the register bank takes it.
    if (accept) pend_d = 1'b0;
    if (fire_c) pend_d = 1'b1;
    if (off_c && !granted) pend_d = 1'b0;

    if (ovr_clr) ovr_d = 1'b0;
    if (fire_c && pend_q && !accept) ovr_d = 1'b1;

    irq_d = fire_c;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      irq_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pend = pend_q;
  assign irq  = irq_q;
  assign ovr  = ovr_q;

endmodule

// File: rtl/pwm_evt_scheduler.sv
// Per-carrier event scheduler: N_CARR channels feeding a round-robin arbiter
// onto the single shadow-register load port.
module pwm_evt_scheduler
  import pwm8carr_pkg::*;
#(
  parameter int unsigned N_CARR = 8,
  parameter int unsigned EVT_W  = `EVTCOUNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CARR-1:0]         evt_zero,
  input  logic [N_CARR-1:0]         evt_prd,
  input  _pwm_onoff                 pwm_onoff   [N_CARR],
  input  _count_mode                countmode   [N_CARR],
  input  _mask_mode                 maskmode    [N_CARR],
  input  logic [EVT_W-1:0]          event_count [N_CARR],
  input  logic [N_CARR-1:0]         ovr_clr,
  output logic                      load_valid,
  output logic [$clog2(N_CARR)-1:0] load_sel,
  input  logic                      load_ready,
  output logic [N_CARR-1:0]         irq,
  output logic [N_CARR-1:0]         ovr
);

  localparam int unsigned SEL_W = $clog2(N_CARR);

  logic              load_valid_q, load_valid_d;
  logic [SEL_W-1:0]  load_sel_q, load_sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  base_c, pick_c;
  logic              found_c, hs_c;
  logic [N_CARR-1:0] pend, granted, accept, avail_c;

  assign hs_c = load_valid_q && load_ready;

  for (genvar i = 0; i < N_CARR; i++) begin : g_chan
    assign granted[i] = load_valid_q && (load_sel_q == SEL_W'(i));
    assign accept[i]  = granted[i] && load_ready;

    pwm_evt_chan #(.EVT_W(EVT_W)) u_chan (
      .clk         (clk),
      .reset       (reset),
      .evt_zero    (evt_zero[i]),
      .evt_prd     (evt_prd[i]),
      .pwm_onoff   (pwm_onoff[i]),
      .countmode   (countmode[i]),
      .maskmode    (maskmode[i]),
      .event_count (event_count[i]),
      .ovr_clr     (ovr_clr[i]),
      .granted     (granted[i]),
      .accept      (accept[i]),
      .pend        (pend[i]),
      .irq         (irq[i]),
      .ovr         (ovr[i])
    );
  end

  // Round-robin pick from registered pend; the carrier accepted this cycle is excluded.
  always_comb begin
    load_valid_d = load_valid_q;
    load_sel_d   = load_sel_q;
    ptr_d        = ptr_q;
    base_c       = ptr_q;
    pick_c       = '0;
    found_c      = 1'b0;
    avail_c      = pend & ~accept;

    if (hs_c) begin
      ptr_d        = (load_sel_q == SEL_W'(N_CARR - 1)) ? '0 : load_sel_q + SEL_W'(1);
      base_c       = ptr_d;
      load_valid_d = 1'b0;
    end

    for (int unsigned off = 0; off < N_CARR; off++) begin
      if (!found_c && avail_c[SEL_W'((32'(base_c) + off) % N_CARR)]) begin
        found_c = 1'b1;
        pick_c  = SEL_W'((32'(base_c) + off) % N_CARR);
      end
    end

    if ((!load_valid_q || hs_c) && found_c) begin
      load_valid_d = 1'b1;
      load_sel_d   = pick_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      load_valid_q <= 1'b0;
      load_sel_q   <= '0;
      ptr_q        <= '0;
    end else begin
      load_valid_q <= load_valid_d;
      load_sel_q   <= load_sel_d;
      ptr_q        <= ptr_d;
    end
  end

  assign load_valid = load_valid_q;
  assign load_sel   = load_sel_q;

endmodule

// File: tb/tb_pwm_evt_scheduler.sv
// Directed bench for pwm_evt_scheduler; inputs driven and outputs sampled on the falling edge.
module tb_pwm_evt_scheduler;
  import pwm8carr_pkg::*;

  localparam int unsigned N = 8;
  localparam int unsigned W = EVTCOUNT_WIDTH;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] evt_zero, evt_prd, ovr_clr, irq, ovr;
  _pwm_onoff    pwm_onoff   [N];
  _count_mode   countmode   [N];
  _mask_mode    maskmode    [N];
  logic [W-1:0] event_count [N];
  logic         load_valid, load_ready;
  logic [2:0]   load_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_evt_scheduler #(.N_CARR(N), .EVT_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .evt_zero    (evt_zero),
    .evt_prd     (evt_prd),
    .pwm_onoff   (pwm_onoff),
    .countmode   (countmode),
    .maskmode    (maskmode),
    .event_count (event_count),
    .ovr_clr     (ovr_clr),
    .load_valid  (load_valid),
    .load_sel    (load_sel),
    .load_ready  (load_ready),
    .irq         (irq),
    .ovr         (ovr)
  );

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Zero strobe on the carriers in mask for one cycle; returns just after the sampling edge.
  task automatic pulse_zero(input logic [N-1:0] mask);
    evt_zero = mask;
    step();
    evt_zero = '0;
  endtask

  task automatic setup(input int c, input _count_mode cm, input _mask_mode mm, input int ec);
    pwm_onoff[c]   = ON;
    countmode[c]   = cm;
    maskmode[c]    = mm;
    event_count[c] = W'(ec);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", load_valid); end
    checks++; if (load_sel !== 3'd0)   begin errors++; $display("FAIL rst_sel: got %0d want 0", load_sel); end
    checks++; if (irq !== 8'h00)       begin errors++; $display("FAIL rst_irq: got %h want 00", irq); end
    checks++; if (ovr !== 8'h00)       begin errors++; $display("FAIL rst_ovr: got %h want 00", ovr); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_decimation();
    logic fire;
    int   irq_seen = 0;
    setup(0, COUNT_ZERO, MASK, 3);
    load_ready = 1'b1;
    step();
    for (int s = 1; s <= 8; s++) begin
      fire = (s % 4 == 0);
      pulse_zero(8'h01);
      if (irq[0]) irq_seen++;
      checks++; if (irq !== {7'd0, fire}) begin errors++; $display("FAIL dec_irq s%0d: got %h want %h", s, irq, {7'd0, fire}); end
      checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL dec_valid_k s%0d: got %b want 0", s, load_valid); end
      step();
      checks++; if (load_valid !== fire) begin errors++; $display("FAIL dec_valid_k1 s%0d: got %b want %b", s, load_valid, fire); end
      if (fire) begin
        checks++; if (load_sel !== 3'd0) begin errors++; $display("FAIL dec_sel s%0d: got %0d want 0", s, load_sel); end
      end
      step();
      if (irq[0]) irq_seen++;
      checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL dec_valid_k2 s%0d: got %b want 0", s, load_valid); end
      step(7);
    end
    checks++; if (irq_seen != 2) begin errors++; $display("FAIL dec_irq_count: got %0d want 2", irq_seen); end
    event_count[0] = '0;
    evt_prd = 8'h01;
    step();
    evt_prd = '0;
    checks++; if (irq !== 8'h00) begin errors++; $display("FAIL dec_prd_ignored: got %h want 00", irq); end
    pwm_onoff[0] = OFF;
    step(3);
  endtask

  task automatic test_no_mask();
    int kinds [5] = '{0, 1, 0, 1, 2};
    setup(1, COUNT_BOTH, NO_MASK, 3);
    step();
    foreach (kinds[j]) begin
      evt_zero[1] = (kinds[j] != 1);
      evt_prd[1]  = (kinds[j] != 0);
      step();
      evt_zero = '0;
      evt_prd  = '0;
      checks++; if (irq !== 8'h02) begin errors++; $display("FAIL nm_irq v%0d: got %h want 02", j, irq); end
      step();
      checks++; if (load_valid !== 1'b1 || load_sel !== 3'd1) begin errors++; $display("FAIL nm_grant v%0d: got %b/%0d want 1/1", j, load_valid, load_sel); end
      step();
      checks++; if (load_valid !== 1'b0 || irq !== 8'h00) begin errors++; $display("FAIL nm_single v%0d: got %b/%h want 0/00", j, load_valid, irq); end
      step(2);
    end
    // Counter must have been held at 0: with decimation 1 the first zero strobe does not fire.
    maskmode[1]    = MASK;
    countmode[1]   = COUNT_ZERO;
    event_count[1] = W'(1);
    step();
    pulse_zero(8'h02);
    checks++; if (irq !== 8'h00) begin errors++; $display("FAIL nm_cnt0: got %h want 00", irq); end
    evt_prd = 8'h02;
    step();
    evt_prd = '0;
    checks++; if (irq !== 8'h00) begin errors++; $display("FAIL nm_prd_ignored: got %h want 00", irq); end
    pulse_zero(8'h02);
    checks++; if (irq !== 8'h02) begin errors++; $display("FAIL nm_second: got %h want 02", irq); end
    step(3);
    pwm_onoff[1] = OFF;
    step();
  endtask

  task automatic test_back_to_back();
    reset = 1'b0;
    step();
    reset = 1'b1;
    setup(2, COUNT_ZERO, NO_MASK, 0);
    setup(5, COUNT_ZERO, NO_MASK, 0);
    setup(7, COUNT_ZERO, NO_MASK, 0);
    load_ready = 1'b1;
    step();
    pulse_zero(8'hA4);
    checks++; if (irq !== 8'hA4) begin errors++; $display("FAIL rr_irq: got %h want a4", irq); end
    step();
    checks++; if (load_valid !== 1'b1 || load_sel !== 3'd2) begin errors++; $display("FAIL rr_g2: got %b/%0d want 1/2", load_valid, load_sel); end
    step();
    checks++; if (load_valid !== 1'b1 || load_sel !== 3'd5) begin errors++; $display("FAIL rr_g5: got %b/%0d want 1/5", load_valid, load_sel); end
    step();
    checks++; if (load_valid !== 1'b1 || load_sel !== 3'd7) begin errors++; $display("FAIL rr_g7: got %b/%0d want 1/7", load_valid, load_sel); end
    step();
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b want 0", load_valid); end
    pulse_zero(8'h24);
    checks++; if (irq !== 8'h24) begin errors++; $display("FAIL rr2_irq: got %h want 24", irq); end
    step();
    checks++; if (load_valid !== 1'b1 || load_sel !== 3'd2) begin errors++; $display("FAIL rr2_g2: got %b/%0d want 1/2", load_valid, load_sel); end
    step();
    checks++; if (load_valid !== 1'b1 || load_sel !== 3'd5) begin errors++; $display("FAIL rr2_g5: got %b/%0d want 1/5", load_valid, load_sel); end
    step();
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL rr2_idle: got %b want 0", load_valid); end
    pwm_onoff[2] = OFF;
    pwm_onoff[5] = OFF;
    pwm_onoff[7] = OFF;
    step();
  endtask

  task automatic test_overrun();
    setup(0, COUNT_ZERO, MASK, 0);
    load_ready = 1'b0;
    step();
    pulse_zero(8'h01);
    checks++; if (irq !== 8'h01 || ovr !== 8'h00) begin errors++; $display("FAIL ov_first: got irq %h ovr %h want 01/00", irq, ovr); end
    step();
    checks++; if (load_valid !== 1'b1 || load_sel !== 3'd0) begin errors++; $display("FAIL ov_req: got %b/%0d want 1/0", load_valid, load_sel); end
    pulse_zero(8'h01);
    checks++; if (ovr !== 8'h01 || irq !== 8'h01) begin errors++; $display("FAIL ov_set: got ovr %h irq %h want 01/01", ovr, irq); end
    step(3);
    checks++; if (load_valid !== 1'b1 || load_sel !== 3'd0 || ovr !== 8'h01) begin errors++; $display("FAIL ov_hold: got %b/%0d ovr %h want 1/0/01", load_valid, load_sel, ovr); end
    ovr_clr = 8'h01;
    step();
    ovr_clr = '0;
    checks++; if (ovr !== 8'h00) begin errors++; $display("FAIL ov_clr: got %h want 00", ovr); end
    evt_zero = 8'h01;
    ovr_clr  = 8'h01;
    step();
    evt_zero = '0;
    ovr_clr  = '0;
    checks++; if (ovr !== 8'h01) begin errors++; $display("FAIL ov_set_wins: got %h want 01", ovr); end
    ovr_clr = 8'h01;
    step();
    ovr_clr = '0;
    checks++; if (ovr !== 8'h00) begin errors++; $display("FAIL ov_clr2: got %h want 00", ovr); end
    load_ready = 1'b1;
    step();
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL ov_hs: got %b want 0", load_valid); end
    step();
    checks++; if (load_valid !== 1'b0 || ovr !== 8'h00) begin errors++; $display("FAIL ov_single: got %b ovr %h want 0/00", load_valid, ovr); end
  endtask

  task automatic test_fire_on_handshake();
    load_ready = 1'b1;
    pulse_zero(8'h01);
    step();
    checks++; if (load_valid !== 1'b1 || load_sel !== 3'd0) begin errors++; $display("FAIL fh_req: got %b/%0d want 1/0", load_valid, load_sel); end
    pulse_zero(8'h01);
    checks++; if (load_valid !== 1'b0 || irq !== 8'h01 || ovr !== 8'h00) begin errors++; $display("FAIL fh_hs: got %b irq %h ovr %h want 0/01/00", load_valid, irq, ovr); end
    step();
    checks++; if (load_valid !== 1'b1 || load_sel !== 3'd0) begin errors++; $display("FAIL fh_rereq: got %b/%0d want 1/0", load_valid, load_sel); end
    step();
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL fh_done: got %b want 0", load_valid); end
    pwm_onoff[0] = OFF;
    step();
  endtask

  task automatic test_runtime_decrease();
    setup(3, COUNT_ZERO, MASK, 7);
    load_ready = 1'b1;
    step();
    for (int s = 1; s <= 5; s++) begin
      pulse_zero(8'h08);
      checks++; if (irq !== 8'h00) begin errors++; $display("FAIL rd_pre s%0d: got %h want 00", s, irq); end
      step();
    end
    event_count[3] = W'(2);
    step();
    pulse_zero(8'h08);
    checks++; if (irq !== 8'h08) begin errors++; $display("FAIL rd_fire: got %h want 08", irq); end
    step();
    checks++; if (load_valid !== 1'b1 || load_sel !== 3'd3) begin errors++; $display("FAIL rd_grant: got %b/%0d want 1/3", load_valid, load_sel); end
    step();
    for (int s = 1; s <= 3; s++) begin
      pulse_zero(8'h08);
      checks++; if (irq !== ((s == 3) ? 8'h08 : 8'h00)) begin errors++; $display("FAIL rd_post s%0d: got %h want %h", s, irq, (s == 3) ? 8'h08 : 8'h00); end
      step(3);
    end
    // Carrier 0 holds the port so carrier 3 stays pending, then carrier 3 is switched off.
    load_ready = 1'b0;
    setup(0, COUNT_ZERO, MASK, 0);
    event_count[3] = '0;
    pulse_zero(8'h01);
    step();
    pulse_zero(8'h08);
    checks++; if (irq !== 8'h08 || load_sel !== 3'd0) begin errors++; $display("FAIL rd_pend: got irq %h sel %0d want 08/0", irq, load_sel); end
    pwm_onoff[3] = OFF;
    step();
    load_ready = 1'b1;
    step();
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL rd_off_nogrant: got %b want 0", load_valid); end
    step(2);
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL rd_off_idle: got %b want 0", load_valid); end
    pwm_onoff[0] = OFF;
    step();
  endtask

  task automatic test_reset_mid();
    setup(4, COUNT_ZERO, MASK, 1);
    load_ready = 1'b0;
    step();
    for (int s = 1; s <= 4; s++) begin
      pulse_zero(8'h10);
      checks++; if (irq !== ((s % 2 == 0) ? 8'h10 : 8'h00)) begin errors++; $display("FAIL rm_irq s%0d: got %h want %h", s, irq, (s % 2 == 0) ? 8'h10 : 8'h00); end
      step();
    end
    checks++; if (ovr !== 8'h10 || load_valid !== 1'b1 || load_sel !== 3'd4) begin errors++; $display("FAIL rm_pre: got ovr %h %b/%0d want 10/1/4", ovr, load_valid, load_sel); end
    pulse_zero(8'h10);
    reset = 1'b0;
    step();
    checks++; if (load_valid !== 1'b0 || load_sel !== 3'd0) begin errors++; $display("FAIL rm_port: got %b/%0d want 0/0", load_valid, load_sel); end
    checks++; if (irq !== 8'h00 || ovr !== 8'h00) begin errors++; $display("FAIL rm_flags: got irq %h ovr %h want 00/00", irq, ovr); end
    reset = 1'b1;
    step();
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL rm_nopend: got %b want 0", load_valid); end
    pulse_zero(8'h10);
    checks++; if (irq !== 8'h00) begin errors++; $display("FAIL rm_restart1: got %h want 00", irq); end
    pulse_zero(8'h10);
    checks++; if (irq !== 8'h10) begin errors++; $display("FAIL rm_restart2: got %h want 10", irq); end
    load_ready = 1'b1;
    step(3);
    pwm_onoff[4] = OFF;
    step();
  endtask

  initial begin
    reset      = 1'b0;
    evt_zero   = '0;
    evt_prd    = '0;
    ovr_clr    = '0;
    load_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      pwm_onoff[i]   = OFF;
      countmode[i]   = NO_COUNT;
      maskmode[i]    = MASK;
      event_count[i] = '0;
    end
    step();
    test_reset();
    test_decimation();
    test_no_mask();
    test_back_to_back();
    test_overrun();
    test_fire_on_handshake();
    test_runtime_decrease();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
